// File: rtl/dac_window_discriminator_if.sv
// Signal bundle for the DAC window discriminator: per-sample inputs, event configuration
// and decision outputs. The discriminator itself uses the slave side.
interface dac_window_discriminator_if #(
    parameter int unsigned NUM_WIN = 2,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 16
) ();

    logic                        enable;
    logic                        sample_valid;
    logic [DATA_W-1:0]           sample;
    logic                        trig;
    logic [NUM_WIN*CNT_W-1:0]    win_start;
    logic [NUM_WIN*CNT_W-1:0]    win_stop;
    logic [NUM_WIN*DATA_W-1:0]   win_level;
    logic [NUM_WIN-1:0]          win_pol;
    logic [NUM_WIN-1:0]          win_excl;
    logic [CNT_W-1:0]            stop_max;
    logic [CNT_W-1:0]            refractory;

    logic                        accept;
    logic                        reject;
    logic                        busy;
    logic [1:0]                  state;
    logic [NUM_WIN-1:0]          win_hit;
    logic [CNT_W-1:0]            sample_idx;

    modport master (
        output enable, sample_valid, sample, trig,
        output win_start, win_stop, win_level, win_pol, win_excl, stop_max, refractory,
        input  accept, reject, busy, state, win_hit, sample_idx
    );

    modport slave (
        input  enable, sample_valid, sample, trig,
        input  win_start, win_stop, win_level, win_pol, win_excl, stop_max, refractory,
        output accept, reject, busy, state, win_hit, sample_idx
    );

endinterface

// File: rtl/dac_window_discriminator.sv
// Triggered time/amplitude window discriminator: after a trigger edge, tracks per-window
// amplitude hits over indexed samples, then emits a one-cycle accept or reject pulse.
module dac_window_discriminator #(
    parameter int unsigned NUM_WIN = 2,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input logic                        dataclk,
    input logic                        reset,
    dac_window_discriminator_if.slave  bus_io
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StTrack   = 2'd1,
        StDecide  = 2'd2,
        StHoldoff = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    state_e                      state_q, state_d;
    logic                        trig_prev_q;
    logic [NUM_WIN-1:0]          win_hit_q, win_hit_d;
    logic [CNT_W-1:0]            sample_idx_q, sample_idx_d;
    logic [CNT_W-1:0]            hold_cnt_q, hold_cnt_d;
    logic                        accept_q, accept_d;
    logic                        reject_q, reject_d;
    logic                        latch_cfg;

    logic [NUM_WIN*CNT_W-1:0]    start_q, stop_q;
    logic [NUM_WIN*DATA_W-1:0]   level_q;
    logic [NUM_WIN-1:0]          pol_q, excl_q;
    logic [CNT_W-1:0]            stop_max_q, refr_q;

    logic                        trigger;
    logic [CNT_W-1:0]            eval_idx;
    logic [NUM_WIN-1:0]          hit_now;
    logic [NUM_WIN-1:0]          pass;
    logic                        use_inputs;

    assign trigger    = bus_io.sample_valid && bus_io.trig && !trig_prev_q;
    // The trigger sample is scored against the config being latched in the same cycle.
    assign use_inputs = (state_q == StIdle);
    assign eval_idx   = use_inputs ? '0 : sample_idx_q;

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        logic [CNT_W-1:0]  lo, hi;
        logic [DATA_W-1:0] lvl;
        logic              pol;
        logic              in_time, in_amp;

        assign lo  = use_inputs ? bus_io.win_start[g*CNT_W +: CNT_W] : start_q[g*CNT_W +: CNT_W];
        assign hi  = use_inputs ? bus_io.win_stop[g*CNT_W +: CNT_W]  : stop_q[g*CNT_W +: CNT_W];
        assign lvl = use_inputs ? bus_io.win_level[g*DATA_W +: DATA_W]
                                : level_q[g*DATA_W +: DATA_W];
        assign pol = use_inputs ? bus_io.win_pol[g] : pol_q[g];

        assign in_time    = (eval_idx >= lo) && (eval_idx <= hi);
        assign in_amp     = pol ? (bus_io.sample >= lvl) : (bus_io.sample <= lvl);
        assign hit_now[g] = in_time && in_amp;
        assign pass[g]    = excl_q[g] ? !win_hit_q[g] : win_hit_q[g];
    end

    always_comb begin
        state_d      = state_q;
        win_hit_d    = win_hit_q;
        sample_idx_d = sample_idx_q;
        hold_cnt_d   = hold_cnt_q;
        accept_d     = 1'b0;
        reject_d     = 1'b0;
        latch_cfg    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Clearing here rather than on the DECIDE exit keeps win_hit visible
                // during the accept/reject cycle.
                win_hit_d    = '0;
                sample_idx_d = '0;
                hold_cnt_d   = '0;
                if (bus_io.enable && trigger) begin
                    latch_cfg    = 1'b1;
                    win_hit_d    = hit_now;
                    sample_idx_d = One;
                    state_d      = (bus_io.stop_max == '0) ? StDecide : StTrack;
                end
            end
            StTrack: begin
                if (!bus_io.enable) begin
                    state_d      = StIdle;
                    win_hit_d    = '0;
                    sample_idx_d = '0;
                end else if (bus_io.sample_valid) begin
                    win_hit_d = win_hit_q | hit_now;
                    if (sample_idx_q != '1) begin
                        sample_idx_d = sample_idx_q + One;
                    end
                    if (sample_idx_q == stop_max_q) begin
                        state_d = StDecide;
                    end
                end
            end
            StDecide: begin
                if (&pass) begin
                    accept_d = 1'b1;
                end else begin
                    reject_d = 1'b1;
                end
                hold_cnt_d = '0;
                state_d    = (refr_q != '0) ? StHoldoff : StIdle;
            end
            StHoldoff: begin
                if (!bus_io.enable) begin
                    state_d      = StIdle;
                    win_hit_d    = '0;
                    sample_idx_d = '0;
                end else if (bus_io.sample_valid) begin
                    if (hold_cnt_q + One == refr_q) begin
                        state_d      = StIdle;
                        win_hit_d    = '0;
                        sample_idx_d = '0;
                        hold_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + One;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q      <= StIdle;
            trig_prev_q  <= 1'b0;
            win_hit_q    <= '0;
            sample_idx_q <= '0;
            hold_cnt_q   <= '0;
            accept_q     <= 1'b0;
            reject_q     <= 1'b0;
            start_q      <= '0;
            stop_q       <= '0;
            level_q      <= '0;
            pol_q        <= '0;
            excl_q       <= '0;
            stop_max_q   <= '0;
            refr_q       <= '0;
        end else begin
            state_q      <= state_d;
            win_hit_q    <= win_hit_d;
            sample_idx_q <= sample_idx_d;
            hold_cnt_q   <= hold_cnt_d;
            accept_q     <= accept_d;
            reject_q     <= reject_d;
            if (bus_io.sample_valid) begin
                trig_prev_q <= bus_io.trig;
            end
            if (latch_cfg) begin
                start_q    <= bus_io.win_start;
                stop_q     <= bus_io.win_stop;
                level_q    <= bus_io.win_level;
                pol_q      <= bus_io.win_pol;
                excl_q     <= bus_io.win_excl;
                stop_max_q <= bus_io.stop_max;
                refr_q     <= bus_io.refractory;
            end
        end
    end

    assign bus_io.accept     = accept_q;
    assign bus_io.reject     = reject_q;
    assign bus_io.busy       = (state_q != StIdle);
    assign bus_io.state      = state_q;
    assign bus_io.win_hit    = win_hit_q;
    assign bus_io.sample_idx = sample_idx_q;

endmodule

// File: doc/dac_window_discriminator.md
DAC_WINDOW_DISCRIMINATOR -- requirements
Module: dac_window_discriminator

Interface
REQ-001 Parameters SHALL be:
- NUM_WIN, default 2, number of time/amplitude windows, 1..8.
- DATA_W, default 16, sample width; samples are unsigned offset-binary.
- CNT_W, default 16, sample-index counter width.

REQ-002 Ports SHALL be:
- dataclk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  discriminator enable.
- sample_valid  in  1  one-cycle strobe marking a new amplitude sample.
- sample  in  DATA_W  amplitude sample, qualified by sample_valid.
- trig  in  1  primary threshold-crossing level, qualified by sample_valid.
- win_start  in  NUM_WIN*CNT_W  per-window first sample index; window i occupies slice i.
- win_stop  in  NUM_WIN*CNT_W  per-window last sample index, inclusive.
- win_level  in  NUM_WIN*DATA_W  per-window amplitude level.
- win_pol  in  NUM_WIN  per window: 0 hit when sample <= level, 1 hit when sample >= level.
- win_excl  in  NUM_WIN  per window: 0 inclusion (must hit), 1 exclusion (must not hit).
- stop_max  in  CNT_W  last sample index evaluated.
- refractory  in  CNT_W  number of valid samples to ignore after a decision.
- accept  out  1  one-cycle pulse when all windows pass.
- reject  out  1  one-cycle pulse when any window fails.
- busy  out  1  high in any state other than IDLE.
- state  out  2  IDLE=0, TRACK=1, DECIDE=2, HOLDOFF=3.
- win_hit  out  NUM_WIN  sticky hit flags for the current event.
- sample_idx  out  CNT_W  index of the next sample to be evaluated.

Function
REQ-003 The block SHALL register trig_prev on every sample_valid cycle. A trigger SHALL be sample_valid && trig && !trig_prev.
- trig_prev SHALL update on sample_valid cycles only, in every state.

REQ-004 IDLE: a trigger with enable=1 SHALL cause all of the following:
- Latch win_start, win_stop, win_level, win_pol, win_excl, stop_max and refractory.
- Evaluate the trigger sample as index 0.
- Set sample_idx=1.
- Go to TRACK, or go to DECIDE if the latched stop_max=0.

REQ-005 Evaluation of a sample at index k SHALL set win_hit[i] when both hold:
- latched start_i <= k <= stop_i;
- the pol_i comparison against level_i is true.
Comparisons SHALL be unsigned. win_hit bits SHALL only be set, never cleared, within an event.

REQ-006 TRACK: each sample_valid SHALL evaluate the sample at index sample_idx and increment sample_idx.
- When the evaluated index equals stop_max, the next state SHALL be DECIDE.
- Cycles without sample_valid SHALL change nothing.

REQ-007 DECIDE SHALL last exactly one cycle and needs no sample_valid.
- pass_i = excl_i ? !hit_i : hit_i.
- accept=1 if every pass_i is 1; otherwise reject=1.
- The pulse SHALL appear the cycle after entering DECIDE, one dataclk wide.
- Next state SHALL be HOLDOFF if latched refractory > 0, else IDLE.

REQ-008 HOLDOFF SHALL count sample_valid cycles and return to IDLE after refractory valid samples.
- Triggers during HOLDOFF SHALL be ignored.

REQ-009 Entering IDLE SHALL clear win_hit and sample_idx. win_hit SHALL remain readable during DECIDE and during the accept/reject cycle.

REQ-010 A window with start > stop, or with start > stop_max, SHALL never hit.
- Exclusion windows of this kind pass; inclusion windows of this kind fail.

REQ-011 enable=0 in TRACK or HOLDOFF SHALL return the block to IDLE next cycle with no accept or reject. A DECIDE already entered SHALL complete.

REQ-012 Config inputs changing mid-event SHALL not affect the current event; only the latched copies are used.

REQ-013 sample_idx SHALL saturate at all-ones and not wrap. stop_max = 2^CNT_W-1 SHALL still reach DECIDE.

REQ-014 Latency from the sample_valid cycle of the sample at index stop_max to the accept/reject pulse SHALL be 2 dataclk cycles.

Reset
REQ-015 reset=1 SHALL force, on the next rising dataclk, all of the following:
- state=IDLE;
- accept=0, reject=0, busy=0;
- win_hit=0, sample_idx=0;
- trig_prev=0, holdoff counter=0, all latched config=0.
reset SHALL take priority over every other input, including mid-event.

Verification
REQ-016 Inclusion hit. NUM_WIN=2; win0=[0,2] level 30650 pol0 incl; win1=[4,6] level 28604 pol0 incl; stop_max=9; refractory=0. Samples idx0=30000, idx5=28000, all others 32768. -> accept pulse 2 cycles after the idx9 sample; win_hit=2'b11; state returns to IDLE.

REQ-017 Exclusion fail. Same stimulus with win_excl=2'b10. -> reject pulse, no accept.

REQ-018 Refractory. refractory=3; a second trig rising edge at 2 valid samples after the decision. -> trigger ignored, no second pulse; IDLE after the 3rd valid sample.

REQ-019 Abort. enable dropped at idx4 during TRACK. -> IDLE the next cycle, no pulse. A later trigger with enable=1 starts a fresh event with win_hit=0.

REQ-020 Edge cases:
- stop_max=0 with win0=[0,0] satisfied -> accept 2 cycles after the trigger sample.
- win1 with start=5, stop=3 incl -> reject.
- reset asserted mid-TRACK -> all outputs 0 next cycle.
